// File: rtl/uart_frame_loader_if.sv
// uart_frame_loader_if: PSDRAM write port (req/ack handshake with address and data)
interface uart_frame_loader_if #(
    parameter int ADDR_W = 23
);
    logic              mem_wr_req;
    logic              mem_wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    modport master(output mem_wr_req, mem_addr, mem_wdata, input mem_wr_ack);
    modport slave(input mem_wr_req, mem_addr, mem_wdata, output mem_wr_ack);
endinterface

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: packs UART byte pairs into 16-bit words, buffers them and
// writes them to sequential PSDRAM addresses, wrapping once per frame.
module uart_frame_loader #(
    parameter int ADDR_W = 23,
    parameter int BASE_ADDR = 0,
    parameter int FRAME_WORDS = 307200,
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int LW = PW + 1
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     ValidData,
    input  logic [7:0]               ReceivedData,
    input  logic                     restart,
    uart_frame_loader_if.master      wr,
    output logic                     frame_done,
    output logic                     overflow,
    output logic [LW-1:0]            fifo_level
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);

    if ((longint'(BASE_ADDR) + longint'(FRAME_WORDS)) > (longint'(1) << ADDR_W) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("uart_frame_loader: invalid parameter combination");
    end

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q, state_d;
    logic              v1_q, v2_q;
    logic              hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              cap, push, pop, full, wr_en, last;

    always_comb begin
        cap     = v1_q & ~v2_q;
        push    = cap & hi_q & ~restart;
        pop     = (state_q == REQ) & wr.mem_wr_ack & ~restart;
        full    = cnt_q == LW'(FIFO_DEPTH);
        wr_en   = push & (~full | pop);
        last    = addr_q == LAST;
        hi_d    = restart ? 1'b0 : (cap ? ~hi_q : hi_q);
        lo_d    = (cap & ~hi_q & ~restart) ? ReceivedData : lo_q;
        wp_d    = restart ? '0 : wp_q + PW'(wr_en);
        rp_d    = restart ? '0 : rp_q + PW'(pop);
        cnt_d   = restart ? '0 : cnt_q + LW'(wr_en) - LW'(pop);
        ovf_d   = ~restart & (ovf_q | (push & full & ~pop));
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        if (restart) begin
            state_d = IDLE;
            req_d   = 1'b0;
            addr_d  = BASE;
        end else if (state_q == IDLE && cnt_q != '0) begin
            state_d = REQ;
            req_d   = 1'b1;
            wdata_d = fifo_q[rp_q];
        end else if (pop) begin
            state_d = IDLE;
            req_d   = 1'b0;
            addr_d  = last ? BASE : addr_q + ADDR_W'(1);
            done_d  = last;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            hi_q    <= 1'b0;
            lo_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v1_q    <= ValidData;
            v2_q    <= v1_q;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // Storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_q[wp_q] <= {ReceivedData, lo_q};
    end

    assign wr.mem_wr_req = req_q;
    assign wr.mem_addr   = addr_q;
    assign wr.mem_wdata  = wdata_q;
    assign frame_done    = done_q;
    assign overflow      = ovf_q;
    assign fifo_level    = cnt_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: table-driven byte pairs plus hand-written overflow, wrap
// and restart sequences; written words are checked against a scoreboard queue.
module tb_uart_frame_loader;
    localparam int AW = 23;
    localparam int BASE = 'h100;
    localparam int FW = 3;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          hold;
        int          dly;
        logic [15:0] word;
    } vec_t;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       ValidData = 1'b0;
    logic [7:0] ReceivedData = 8'h00;
    logic       restart = 1'b0;
    logic       frame_done, overflow;
    logic [2:0] fifo_level;

    uart_frame_loader_if #(.ADDR_W(AW)) bus();

    uart_frame_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .RST(RST), .ValidData(ValidData), .ReceivedData(ReceivedData),
        .restart(restart), .wr(bus.master), .frame_done(frame_done),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    int          exp_addr = BASE;
    bit          done_exp = 0;
    int          done_cnt = 0;
    int          nwrites = 0;
    int          hold = 0;
    int          last_hold = 0;
    bit          ack_en = 1;
    bit          force_ack = 0;
    int          ack_dly = 1;
    int          wcnt = 0;
    vec_t        vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            #2;
            if (frame_done || done_exp) begin
                chk("frame_done", int'(frame_done), int'(done_exp));
                if (frame_done) done_cnt++;
            end
            done_exp = 0;
            hold = bus.mem_wr_req ? hold + 1 : 0;
            if (bus.mem_wr_req && bus.mem_wr_ack && !restart && !RST) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    chk("wdata", int'(bus.mem_wdata), int'(sb.pop_front()));
                    chk("addr", int'(bus.mem_addr), exp_addr);
                end
                done_exp = exp_addr == BASE + FW - 1;
                exp_addr = done_exp ? BASE : exp_addr + 1;
                last_hold = hold;
                nwrites++;
            end
            if (restart || RST) begin
                exp_addr = BASE;
                done_exp = 0;
            end
        end
    endtask

    task automatic acker();
        forever begin
            @(negedge clk);
            if (force_ack) bus.mem_wr_ack = 1'b1;
            else if (ack_en && bus.mem_wr_req && !bus.mem_wr_ack) begin
                wcnt++;
                if (wcnt >= ack_dly) begin
                    bus.mem_wr_ack = 1'b1;
                    wcnt = 0;
                end
            end else begin
                bus.mem_wr_ack = 1'b0;
                if (!bus.mem_wr_req) wcnt = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi_cyc, input int gap);
        @(negedge clk);
        ValidData = 1'b1;
        ReceivedData = b;
        repeat (hi_cyc) @(negedge clk);
        ValidData = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.mem_wr_req) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending words expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        sb.delete();
    endtask

    initial begin
        int d0, n0, n;
        vecs[0] = '{8'h34, 8'h12, 8, 3, 16'h1234};
        vecs[1] = '{8'hAA, 8'h55, 20, 1, 16'h55AA};
        vecs[2] = '{8'h00, 8'hFF, 2, 1, 16'hFF00};
        vecs[3] = '{8'hFF, 8'h80, 3, 2, 16'h80FF};
        vecs[4] = '{8'h5A, 8'hA5, 4, 4, 16'hA55A};
        vecs[5] = '{8'h01, 8'h00, 5, 1, 16'h0001};
        bus.mem_wr_ack = 1'b0;
        fork
            monitor();
            acker();
        join_none
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_req", int'(bus.mem_wr_req), 0);
        chk("rst_addr", int'(bus.mem_addr), BASE);
        chk("rst_wdata", int'(bus.mem_wdata), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);

        for (int i = 0; i < 6; i++) begin
            ack_dly = vecs[i].dly;
            sb.push_back(vecs[i].word);
            send_byte(vecs[i].lo, vecs[i].hold, 4);
            send_byte(vecs[i].hi, vecs[i].hold, 4);
            drain();
            chk("req_hold", last_hold, vecs[i].dly);
            chk("fifo_level_idle", int'(fifo_level), 0);
            chk("overflow_idle", int'(overflow), 0);
        end

        // frame wrap with immediate acks
        pulse_restart();
        ack_dly = 1;
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            sb.push_back({8'(8'h20 + k), 8'(8'h10 + k)});
            send_byte(8'(8'h10 + k), 3, 2);
            send_byte(8'(8'h20 + k), 3, 2);
        end
        drain();
        chk("frame_done_count", done_cnt - d0, 1);

        // overflow: acks held off, fifth word dropped
        pulse_restart();
        ack_en = 0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) sb.push_back({8'(16 * k + 2), 8'(16 * k + 1)});
            send_byte(8'(16 * k + 1), 3, 2);
            send_byte(8'(16 * k + 2), 3, 2);
        end
        repeat (4) @(negedge clk);
        #2;
        chk("ovf_fifo_level", int'(fifo_level), 4);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_req_waiting", int'(bus.mem_wr_req), 1);
        n0 = nwrites;
        ack_en = 1;
        drain();
        chk("ovf_write_count", nwrites - n0, 4);
        chk("ovf_sticky", int'(overflow), 1);
        pulse_restart();
        #2;
        chk("ovf_cleared", int'(overflow), 0);

        // stale low byte discarded by restart
        send_byte(8'h77, 3, 3);
        pulse_restart();
        n0 = nwrites;
        sb.push_back(16'h0201);
        send_byte(8'h01, 3, 3);
        send_byte(8'h02, 3, 3);
        drain();
        chk("stale_write_count", nwrites - n0, 1);

        // restart abandons an outstanding request; late ack ignored
        pulse_restart();
        ack_en = 0;
        send_byte(8'hCD, 3, 3);
        send_byte(8'hAB, 3, 3);
        n = 0;
        while (!bus.mem_wr_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abandon_req_seen", int'(bus.mem_wr_req), 1);
        n0 = nwrites;
        pulse_restart();
        #2;
        chk("abandon_req_drop", int'(bus.mem_wr_req), 0);
        chk("abandon_fifo_level", int'(fifo_level), 0);
        @(posedge clk);
        #1 force_ack = 1;
        @(posedge clk);
        #1 force_ack = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("late_ack_addr", int'(bus.mem_addr), BASE);
        chk("late_ack_req", int'(bus.mem_wr_req), 0);
        chk("late_ack_fifo", int'(fifo_level), 0);
        chk("late_ack_writes", nwrites - n0, 0);
        ack_en = 1;
        sb.push_back(16'h4321);
        send_byte(8'h21, 3, 3);
        send_byte(8'h43, 3, 3);
        drain();
        chk("post_restart_writes", nwrites - n0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
